// File: rtl/jpeg_pipe_ctrl.sv
// Frame sequencer for a fixed-latency, free-running pixel datapath.
// Tags {valid, sob, eob, last} travel in a shift register matched to LATENCY.
module jpeg_pipe_ctrl #(
    parameter int LATENCY     = 4,
    parameter int BLK_SAMPLES = 64,
    parameter int BLK_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_sob,
    output logic             out_eob,
    output logic             out_last,
    output logic [BLK_W-1:0] blk_idx,
    output logic             busy,
    output logic             done
);

    localparam int SW = (BLK_SAMPLES > 1) ? $clog2(BLK_SAMPLES) : 1;
    localparam int DW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [SW-1:0]    scnt_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] nb_q;
    logic [DW-1:0]    dcnt_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       sr_q [LATENCY];

    logic       acc;
    logic       s_first;
    logic       s_last;
    logic       b_last;
    logic [3:0] tag_d;

    assign acc     = in_valid && in_ready_q;
    assign s_first = (scnt_q == '0);
    assign s_last  = (scnt_q == SW'(BLK_SAMPLES - 1));
    // nb_q is never zero while RUN, so the decrement cannot wrap there
    assign b_last  = (blk_q == nb_q - BLK_W'(1));
    assign tag_d   = {acc,
                      acc && s_first,
                      acc && s_last,
                      acc && s_last && b_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) sr_q[i] <= '0;
        end else if (abort) begin
            for (int i = 0; i < LATENCY; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= tag_d;
            for (int i = 1; i < LATENCY; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            blk_q      <= '0;
            nb_q       <= '0;
            dcnt_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            blk_q      <= '0;
            nb_q       <= '0;
            dcnt_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        scnt_q <= '0;
                        blk_q  <= '0;
                        busy_q <= 1'b1;
                        if (num_blocks != '0) begin
                            nb_q       <= num_blocks;
                            state_q    <= S_RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (acc) begin
                        scnt_q <= scnt_q + SW'(1);
                        if (s_last) begin
                            if (b_last) begin
                                state_q    <= S_DRAIN;
                                in_ready_q <= 1'b0;
                                dcnt_q     <= '0;
                            end else begin
                                blk_q <= blk_q + BLK_W'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // final tag reaches the output on the LATENCY-th drain cycle
                    if (dcnt_q == DW'(LATENCY - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = sr_q[LATENCY-1][3];
    assign out_sob   = sr_q[LATENCY-1][2];
    assign out_eob   = sr_q[LATENCY-1][1];
    assign out_last  = sr_q[LATENCY-1][0];
    assign blk_idx   = blk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jpeg_pipe_ctrl.sv
// Randomised and directed bench for jpeg_pipe_ctrl against a frame-level
// model built from sample counts and a queue of per-cycle output tags.
module tb_jpeg_pipe_ctrl;

    localparam int L  = 4;
    localparam int BS = 64;
    localparam int BW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [BW-1:0] num_blocks;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_sob;
    logic          out_eob;
    logic          out_last;
    logic [BW-1:0] blk_idx;
    logic          busy;
    logic          done;

    jpeg_pipe_ctrl #(
        .LATENCY    (L),
        .BLK_SAMPLES(BS),
        .BLK_W      (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_blocks(num_blocks),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_last  (out_last),
        .blk_idx   (blk_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // frame-level model: phase, samples accepted, output tag history
    typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} ph_t;
    ph_t ph;
    int  k, n_tot, nbl, blk, dleft;
    int  hist[$];

    task automatic model_reset();
        ph = P_IDLE; k = 0; n_tot = 0; nbl = 0; blk = 0; dleft = 0;
        hist = {};
        for (int i = 0; i < L; i++) hist.push_back(0);
    endtask

    task automatic model_step();
        int tag, s;
        bit a;
        if (abort) begin
            model_reset();
            return;
        end
        a = in_valid && (ph == P_RUN);
        tag = 0;
        if (a) begin
            s = k % BS;
            tag = 8 | ((s == 0) ? 4 : 0) | ((s == BS-1) ? 2 : 0)
                    | ((k == n_tot-1) ? 1 : 0);
            k++;
        end
        hist.push_back(tag);
        void'(hist.pop_front());
        case (ph)
            P_IDLE: if (start) begin
                blk = 0; k = 0;
                if (num_blocks != 0) begin
                    nbl = int'(num_blocks); n_tot = nbl * BS; ph = P_RUN;
                end else ph = P_DONE;
            end
            P_RUN: if (k < n_tot) blk = k / BS;
                   else begin blk = nbl - 1; ph = P_DRAIN; dleft = L; end
            P_DRAIN: begin dleft--; if (dleft == 0) ph = P_DONE; end
            default: ph = P_IDLE;
        endcase
    endtask

    // monitor counters for the literal checks
    int cyc = 0;
    int c_val, c_sob, c_eob, c_last, c_done, c_busy, c_rdy, c_acc;
    int f_acc, f_val, last_cyc, done_cyc, busy_end;

    task automatic clr_mon();
        c_val = 0; c_sob = 0; c_eob = 0; c_last = 0; c_done = 0;
        c_busy = 0; c_rdy = 0; c_acc = 0;
        f_acc = -1; f_val = -1; last_cyc = -1; done_cyc = -1; busy_end = -1;
    endtask

    always @(negedge clk) begin
        int t;
        cyc++;
        if (!rst_n) begin
            model_reset();
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_blk_idx", int'(blk_idx), 0);
        end else begin
            t = hist[0];
            chk("out_valid", int'(out_valid), (t >> 3) & 1);
            chk("out_sob", int'(out_sob), (t >> 2) & 1);
            chk("out_eob", int'(out_eob), (t >> 1) & 1);
            chk("out_last", int'(out_last), t & 1);
            chk("in_ready", int'(in_ready), int'(ph == P_RUN));
            chk("busy", int'(busy), int'(ph != P_IDLE));
            chk("done", int'(done), int'(ph == P_DONE));
            chk("blk_idx", int'(blk_idx), blk);
            if (in_valid && in_ready) begin
                c_acc++;
                if (f_acc < 0) f_acc = cyc;
            end
            if (out_valid) begin
                c_val++;
                if (f_val < 0) f_val = cyc;
            end
            if (out_sob) c_sob++;
            if (out_eob) c_eob++;
            if (out_last) begin c_last++; last_cyc = cyc; end
            if (done) begin c_done++; done_cyc = cyc; end
            if (busy) begin c_busy++; busy_end = cyc; end
            if (in_ready) c_rdy++;
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // toggle=1 flips in_valid every cycle while waiting
    task automatic wait_idle(input int limit, input bit toggle);
        int n;
        n = 0;
        while (busy && n < limit) begin
            if (toggle) in_valid = ~in_valid;
            step();
            n++;
        end
        if (busy) begin
            n_err++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", limit);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int limit);
        int w;
        w = 0;
        while (c_acc < n && w < limit) begin step(); w++; end
        if (c_acc < n) begin
            n_err++;
            $display("FAIL wait_acc: got %0d accepts expected %0d", c_acc, n);
        end
    endtask

    task automatic go(input int nb);
        num_blocks = BW'(nb);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        model_reset();
        clr_mon();
        rst_n = 1'b0; start = 1'b0; num_blocks = '0;
        abort = 1'b0; in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(in_ready), 0);

        // single block, in_valid held high
        clr_mon();
        in_valid = 1'b1;
        go(1);
        wait_idle(300, 1'b0);
        repeat (3) step();
        chk("t1_valid_cnt", c_val, 64);
        chk("t1_sob_cnt", c_sob, 1);
        chk("t1_eob_cnt", c_eob, 1);
        chk("t1_last_cnt", c_last, 1);
        chk("t1_done_cnt", c_done, 1);
        chk("t1_latency", f_val - f_acc, L);
        chk("t1_done_after_last", done_cyc - last_cyc, 1);
        chk("t1_busy_end", busy_end, done_cyc);

        // two blocks, in_valid toggling
        clr_mon();
        in_valid = 1'b1;
        go(2);
        wait_idle(600, 1'b1);
        repeat (3) step();
        chk("t2_valid_cnt", c_val, 128);
        chk("t2_sob_cnt", c_sob, 2);
        chk("t2_eob_cnt", c_eob, 2);
        chk("t2_blk_final", int'(blk_idx), 1);

        // empty frame
        clr_mon();
        go(0);
        wait_idle(10, 1'b0);
        repeat (3) step();
        chk("t3_busy_cnt", c_busy, 1);
        chk("t3_done_cnt", c_done, 1);
        chk("t3_ready_cnt", c_rdy, 0);
        chk("t3_valid_cnt", c_val, 0);

        // start during RUN is ignored
        clr_mon();
        in_valid = 1'b1;
        go(1);
        repeat (20) step();
        num_blocks = BW'(5); start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(300, 1'b0);
        repeat (3) step();
        chk("t4_valid_cnt", c_val, 64);
        chk("t4_done_cnt", c_done, 1);

        // abort after 30 samples, then a fresh frame
        clr_mon();
        in_valid = 1'b1;
        go(1);
        wait_acc(30, 100);
        abort = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("t5_ready_after_abort", int'(in_ready), 0);
        chk("t5_valid_after_abort", int'(out_valid), 0);
        repeat (L + 3) step();
        chk("t5_no_done", c_done, 0);
        clr_mon();
        in_valid = 1'b1;
        go(1);
        wait_idle(300, 1'b0);
        repeat (3) step();
        chk("t5_restart_sob", c_sob, 1);
        chk("t5_restart_valid", c_val, 64);

        // async reset at sample 10 of block 1
        clr_mon();
        in_valid = 1'b1;
        go(3);
        wait_acc(74, 200);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(out_valid), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_ready", int'(in_ready), 0);
        chk("t6_async_blk", int'(blk_idx), 0);
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        clr_mon();
        repeat (L + 2) step();
        chk("t6_no_stale_tags", c_val, 0);
        chk("t6_idle_busy", int'(busy), 0);

        // random traffic, occasional stray starts and aborts
        for (int f = 0; f < 6; f++) begin
            in_valid = 1'b1;
            go(int'($urandom_range(1, 3)));
            for (int c = 0; c < 700; c++) begin
                in_valid = ($urandom % 4) != 0;
                start = ($urandom % 60) == 0;
                num_blocks = BW'($urandom_range(0, 3));
                abort = ($urandom % 400) == 0;
                step();
            end
            start = 1'b0; abort = 1'b0;
            in_valid = 1'b1;
            wait_idle(1000, 1'b0);
            step();
        end

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
